db9md_scan_ctrl: RTL and testbench

//  Scan sequencer for the user-port DB9 Mega Drive adapter, feeding the SNAC joystick path.

---
 rtl/db9md_pkg.sv | 77 +++++++
 rtl/db9md_sync2.sv | 31 +++
 rtl/db9md_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_db9md_scan_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/db9md_pkg.sv
`default_nettype none
// ============================================================================
// db9md_pkg : shared types and bit maps for the DB9 Mega Drive scan controller
// Rev 1.0
// ============================================================================
package db9md_pkg;

  typedef enum logic [1:0] {
    ST_IDLE_WAIT = 2'd0,
    ST_SCAN      = 2'd1,
    ST_COMMIT    = 2'd2
  } state_t;

  // Published button word layout
  localparam int BTN_R     = 0;
  localparam int BTN_L     = 1;
  localparam int BTN_D     = 2;
  localparam int BTN_U     = 3;
  localparam int BTN_B     = 4;
  localparam int BTN_C     = 5;
  localparam int BTN_A     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_MODE  = 8;
  localparam int BTN_X     = 9;
  localparam int BTN_Y     = 10;
  localparam int BTN_Z     = 11;

  // joy_in pin map; meaning depends on the select phase
  localparam int JOY_U     = 0;
  localparam int JOY_D     = 1;
  localparam int JOY_L     = 2;
  localparam int JOY_R     = 3;
  localparam int JOY_B     = 4;
  localparam int JOY_C     = 5;
  localparam int JOY_A     = 4;
  localparam int JOY_START = 5;
  localparam int JOY_Z     = 0;
  localparam int JOY_Y     = 1;
  localparam int JOY_X     = 2;
  localparam int JOY_MODE  = 3;

  localparam logic [2:0] PH_DIR  = 3'd0;
  localparam logic [2:0] PH_AST  = 3'd1;
  localparam logic [2:0] PH_ID   = 3'd5;
  localparam logic [2:0] PH_XYZ  = 3'd6;
  localparam logic [2:0] PH_LAST = 3'd7;

  // Captures are already active-high and kept in joy_in pin order.
  function automatic logic [11:0] pack_word(
    input logic [5:0] dir,
    input logic [5:0] ast,
    input logic [5:0] xyz,
    input logic       present,
    input logic       six
  );
    logic [11:0] w;
    w            = '0;
    w[BTN_R]     = dir[JOY_R];
    w[BTN_L]     = dir[JOY_L];
    w[BTN_D]     = dir[JOY_D];
    w[BTN_U]     = dir[JOY_U];
    w[BTN_B]     = dir[JOY_B];
    w[BTN_C]     = dir[JOY_C];
    w[BTN_A]     = ast[JOY_A];
    w[BTN_START] = ast[JOY_START];
    if (six) begin
      w[BTN_MODE] = xyz[JOY_MODE];
      w[BTN_X]    = xyz[JOY_X];
      w[BTN_Y]    = xyz[JOY_Y];
      w[BTN_Z]    = xyz[JOY_Z];
    end
    if (!present) w = '0;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/db9md_sync2.sv
`default_nettype none
// ============================================================================
// db9md_sync2 : 2-flop synchronizer, resets to all ones (idle, active-low bus)
// Rev 1.0
// ============================================================================
module db9md_sync2 #(
  parameter int WIDTH = 6
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/db9md_scan_ctrl.sv
`default_nettype none
// ============================================================================
// db9md_scan_ctrl : DB9 Mega Drive select-line sequencer and pad decoder
// Rev 1.0
// ============================================================================
module db9md_scan_ctrl
  import db9md_pkg::*;
#(
  parameter int PHASE_CYC = 480,
  parameter int IDLE_CYC  = 96000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        two_pad,
  input  logic [5:0]  joy_in,
  output logic        joy_mdsel,
  output logic        joy_split,
  output logic [11:0] joystick1,
  output logic [11:0] joystick2,
  output logic [1:0]  pad_present,
  output logic [1:0]  pad_6btn,
  output logic        scan_done
);

  localparam int CNT_MAX = (IDLE_CYC > PHASE_CYC) ? IDLE_CYC : PHASE_CYC;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYC - 1);

  logic [5:0]       w_joy_s;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_phase, w_phase_nxt;
  logic             w_sample;
  logic             w_commit;

  logic [5:0]       r_cap_dir, r_cap_ast, r_cap_xyz;
  logic             r_cap_present, r_cap_six;
  logic [11:0]      w_word;

  logic             r_mdsel, r_split, r_done;
  logic [11:0]      r_joy1, r_joy2;
  logic [1:0]       r_present, r_6btn;

  db9md_sync2 #(.WIDTH(6)) u_sync (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .d       (joy_in),
    .q       (w_joy_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_phase_nxt = r_phase;
    w_sample    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE_WAIT: begin
        if (r_cnt == IDLE_LAST) begin
          w_state_nxt = ST_SCAN;
          w_cnt_nxt   = '0;
          w_phase_nxt = PH_DIR;
        end
      end
      ST_SCAN: begin
        if (r_cnt == PHASE_LAST) begin
          w_sample  = 1'b1;
          w_cnt_nxt = '0;
          if (r_phase == PH_LAST) begin
            w_state_nxt = ST_COMMIT;
            w_commit    = 1'b1;
          end else begin
            w_phase_nxt = r_phase + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE_WAIT;
        w_cnt_nxt   = '0;
      end
    endcase
    // Dropping enable aborts anything in flight, including a pending commit.
    if (!enable) begin
      w_state_nxt = ST_IDLE_WAIT;
      w_cnt_nxt   = '0;
      w_phase_nxt = '0;
      w_sample    = 1'b0;
      w_commit    = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE_WAIT;
      r_cnt   <= '0;
      r_phase <= '0;
      r_mdsel <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
      r_mdsel <= !((w_state_nxt == ST_SCAN) && w_phase_nxt[0]);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cap_dir     <= '0;
      r_cap_ast     <= '0;
      r_cap_xyz     <= '0;
      r_cap_present <= 1'b0;
      r_cap_six     <= 1'b0;
    end else if (!enable) begin
      r_cap_dir     <= '0;
      r_cap_ast     <= '0;
      r_cap_xyz     <= '0;
      r_cap_present <= 1'b0;
      r_cap_six     <= 1'b0;
    end else if (w_sample) begin
      case (r_phase)
        PH_DIR: r_cap_dir <= ~w_joy_s;
        PH_AST: begin
          r_cap_ast     <= ~w_joy_s;
          // L and R both low while select is low is the MD signature.
          r_cap_present <= !w_joy_s[JOY_L] && !w_joy_s[JOY_R];
        end
        PH_ID:  r_cap_six <= (w_joy_s[3:0] == 4'b0000);
        PH_XYZ: r_cap_xyz <= ~w_joy_s;
        default: ;
      endcase
    end
  end

  assign w_word = pack_word(r_cap_dir, r_cap_ast, r_cap_xyz, r_cap_present, r_cap_six);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_joy1    <= '0;
      r_joy2    <= '0;
      r_present <= '0;
      r_6btn    <= '0;
      r_split   <= 1'b0;
      r_done    <= 1'b0;
    end else if (!enable) begin
      r_joy1    <= '0;
      r_joy2    <= '0;
      r_present <= '0;
      r_6btn    <= '0;
      r_split   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_commit) begin
        if (r_split) r_joy2 <= w_word;
        else         r_joy1 <= w_word;
        r_present[r_split] <= r_cap_present;
        r_6btn[r_split]    <= r_cap_present && r_cap_six;
        r_split            <= two_pad ? !r_split : 1'b0;
      end
    end
  end

  assign joy_mdsel   = r_mdsel;
  assign joy_split   = r_split;
  assign joystick1   = r_joy1;
  assign joystick2   = r_joy2;
  assign pad_present = r_present;
  assign pad_6btn    = r_6btn;
  assign scan_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_db9md_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_db9md_scan_ctrl : directed bench with behavioural MD pad models
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_db9md_scan_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        two_pad;
  logic [5:0]  joy_in;
  logic        joy_mdsel, joy_split, scan_done;
  logic [11:0] joystick1, joystick2;
  logic [1:0]  pad_present, pad_6btn;

  int n_cmp  = 0;
  int n_fail = 0;

  // pad models: presence, 6-button capability, active-high buttons in output layout
  logic        p0_on, p0_six, p1_on, p1_six;
  logic [11:0] p0_btn, p1_btn;
  int          m_falls = 0;
  int          m_hi    = 0;
  logic        m_prev  = 1'b1;

  db9md_scan_ctrl #(.PHASE_CYC(4), .IDLE_CYC(16)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .enable      (enable),
    .two_pad     (two_pad),
    .joy_in      (joy_in),
    .joy_mdsel   (joy_mdsel),
    .joy_split   (joy_split),
    .joystick1   (joystick1),
    .joystick2   (joystick2),
    .pad_present (pad_present),
    .pad_6btn    (pad_6btn),
    .scan_done   (scan_done)
  );

  always #5 clk_sys = ~clk_sys;

  // Select-low count since the pad's idle timeout; 6-button pads reveal ID on the 3rd.
  always @(negedge clk_sys) begin
    if (joy_mdsel) begin
      if (m_hi < 100) m_hi <= m_hi + 1;
      if (m_hi > 8) m_falls <= 0;
    end else begin
      if (m_prev) m_falls <= m_falls + 1;
      m_hi <= 0;
    end
    m_prev <= joy_mdsel;
  end

  function automatic logic [5:0] pad_out(input logic on, input logic six,
                                         input logic [11:0] b, input logic sel,
                                         input int falls);
    logic [5:0] act;
    if (!on) return 6'h3F;
    if (sel) begin
      if (six && falls == 3) act = {b[5], b[4], b[8], b[9], b[10], b[11]};
      else                   act = {b[5], b[4], b[0], b[1], b[2], b[3]};
    end else begin
      if (six && falls == 3) act = {b[7], b[6], 4'b1111};
      else                   act = {b[7], b[6], 2'b11, b[2], b[3]};
    end
    return ~act;
  endfunction

  assign joy_in = joy_split ? pad_out(p1_on, p1_six, p1_btn, joy_mdsel, m_falls)
                            : pad_out(p0_on, p0_six, p0_btn, joy_mdsel, m_falls);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_done(input int max, output int n);
    logic found;
    found = 1'b0;
    n = 0;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (scan_done) begin
        n = i;
        found = 1'b1;
        break;
      end
    end
    chk("scan_done_arrives", {31'd0, found}, 32'd1);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_mdsel"},   {31'd0, joy_mdsel}, 32'd1);
    chk({tag, "_split"},   {31'd0, joy_split}, 32'd0);
    chk({tag, "_joy1"},    {20'd0, joystick1}, 32'd0);
    chk({tag, "_joy2"},    {20'd0, joystick2}, 32'd0);
    chk({tag, "_present"}, {30'd0, pad_present}, 32'd0);
    chk({tag, "_6btn"},    {30'd0, pad_6btn}, 32'd0);
    chk({tag, "_done"},    {31'd0, scan_done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fall_edge, done_edge, falls_seen, dones;
    logic prev_sel;
    reset_n = 1'b0; enable = 1'b0; two_pad = 1'b0;
    p0_on = 1'b1; p0_six = 1'b1; p0_btn = 12'h840;   // A + Z
    p1_on = 1'b0; p1_six = 1'b0; p1_btn = 12'h000;
    repeat (3) tick();
    chk_cleared("reset");

    // Release and enable before edge 1; count edges from there.
    #3;
    reset_n = 1'b1;
    enable  = 1'b1;
    fall_edge = 0; done_edge = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (i == 10) chk("idle_mdsel", {31'd0, joy_mdsel}, 32'd1);
      if (!joy_mdsel && fall_edge == 0) fall_edge = i;
      if (scan_done) begin
        done_edge = i;
        break;
      end
    end
    chk("first_mdsel_fall", fall_edge, 32'd20);
    chk("first_scan_done",  done_edge, 32'd48);
    chk("6btn_joy1",    {20'd0, joystick1},   32'h840);
    chk("6btn_present", {30'd0, pad_present}, 32'h1);
    chk("6btn_flag",    {30'd0, pad_6btn},    32'h1);
    chk("6btn_split",   {31'd0, joy_split},   32'd0);
    tick();
    chk("done_one_cycle", {31'd0, scan_done}, 32'd0);

    // 3-button pad, Start + Right
    p0_six = 1'b0; p0_btn = 12'h081;
    wait_done(80, n);
    chk("scan_period",   n, 32'd48);
    chk("3btn_joy1",     {20'd0, joystick1},   32'h081);
    chk("3btn_present",  {30'd0, pad_present}, 32'h1);
    chk("3btn_flag",     {30'd0, pad_6btn},    32'h0);

    // No pad: bus idles high
    p0_on = 1'b0;
    wait_done(80, n);
    chk("absent_joy1",    {20'd0, joystick1},   32'h000);
    chk("absent_present", {30'd0, pad_present}, 32'h0);
    chk("absent_flag",    {30'd0, pad_6btn},    32'h0);

    // Two pads: pad0 3-btn B, pad1 6-btn Up
    p0_on = 1'b1; p0_six = 1'b0; p0_btn = 12'h010;
    p1_on = 1'b1; p1_six = 1'b1; p1_btn = 12'h008;
    two_pad = 1'b1;
    wait_done(80, n);
    chk("two_p0_joy1",    {20'd0, joystick1},   32'h010);
    chk("two_p0_joy2",    {20'd0, joystick2},   32'h000);
    chk("two_p0_split",   {31'd0, joy_split},   32'd1);
    chk("two_p0_present", {30'd0, pad_present}, 32'h1);
    wait_done(80, n);
    chk("two_p1_joy2",    {20'd0, joystick2},   32'h008);
    chk("two_p1_joy1",    {20'd0, joystick1},   32'h010);
    chk("two_p1_split",   {31'd0, joy_split},   32'd0);
    chk("two_p1_present", {30'd0, pad_present}, 32'h3);
    chk("two_p1_flag",    {30'd0, pad_6btn},    32'h2);

    // Drop enable in phase 3 (second select-low)
    falls_seen = 0;
    prev_sel = joy_mdsel;
    for (int i = 0; i < 60 && falls_seen < 2; i++) begin
      tick();
      if (prev_sel && !joy_mdsel) falls_seen++;
      prev_sel = joy_mdsel;
    end
    chk("reached_phase3", falls_seen, 32'd2);
    tick();
    enable = 1'b0;
    tick();
    chk_cleared("disable");
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (scan_done) dones++;
    end
    chk("disabled_no_done", dones, 32'd0);
    enable = 1'b1;
    wait_done(80, n);
    chk("reenable_latency", n, 32'd48);
    chk("reenable_joy1",    {20'd0, joystick1}, 32'h010);
    chk("reenable_joy2",    {20'd0, joystick2}, 32'h000);

    // Asynchronous reset mid-scan
    for (int i = 0; i < 60 && joy_mdsel; i++) tick();
    chk("in_scan_before_reset", {31'd0, joy_mdsel}, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_cleared("async_reset");
    reset_n = 1'b1;
    wait_done(80, n);
    chk("post_reset_latency", n, 32'd48);
    chk("post_reset_joy1",    {20'd0, joystick1},   32'h010);
    chk("post_reset_joy2",    {20'd0, joystick2},   32'h000);
    chk("post_reset_present", {30'd0, pad_present}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
